dmem_responder: RTL and testbench

//  Responder end of the processor data-memory interface: accepts one Rd or Wr request

---
 rtl/dmem_responder_if.sv | 31 +++
 rtl/dmem_responder.sv | 122 ++++++++++++
 tb/tb_dmem_responder.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - core-to-data-memory request/response bundle
// Purpose: groups the data-memory handshake between the core memory stage
//          (master) and the data-memory responder (slave).
// Signals:
//   Addr    [15:0] byte address, Addr[0] selects the byte    (master -> slave)
//   DataIn  [15:0] write data                                 (master -> slave)
//   Rd, Wr         read / write request, held until Done      (master -> slave)
//   DataOut [15:0] read data, valid with Done and held        (slave -> master)
//   Stall          core must not advance                      (slave -> master)
//   Done           one-cycle completion pulse                 (slave -> master)
//   Err            one-cycle illegal-request pulse            (slave -> master)
interface dmem_responder_if;
   logic [15:0] Addr;
   logic [15:0] DataIn;
   logic        Rd;
   logic        Wr;
   logic [15:0] DataOut;
   logic        Stall;
   logic        Done;
   logic        Err;

   modport master (
      output Addr, DataIn, Rd, Wr,
      input  DataOut, Stall, Done, Err
   );

   modport slave (
      input  Addr, DataIn, Rd, Wr,
      output DataOut, Stall, Done, Err
   );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder with stall/done handshake
// Purpose: accepts one Rd or Wr request from the core, holds Stall for a fixed
//          LATENCY-cycle access into a 16-bit word array, then pulses Done.
//          Single outstanding request; inputs are captured only at acceptance.
// Parameters:
//   LATENCY    cycles from acceptance to Done (1..15)
//   ADDR_WORDS log2 of array depth in words; word index = Addr[ADDR_WORDS:1]
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  dmem_responder_if.slave (Addr, DataIn, Rd, Wr in; DataOut, Stall, Done, Err out)
// Configuration:
//   DMEM_ALIGN_CHK_EN  when defined, odd byte addresses are rejected with Err;
//                      when undefined, Addr[0] is ignored.
module dmem_responder #(
   parameter int LATENCY    = 4,
   parameter int ADDR_WORDS = 10
) (
   input  logic              clk,
   input  logic              rst,
   dmem_responder_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

   state_t                  state_q;
   logic [3:0]              count_q;
   logic [ADDR_WORDS-1:0]   addr_q;
   logic [15:0]             wdata_q;
   logic                    wr_q;
   logic [15:0]             dout_q;
   logic                    done_q;
   logic                    err_q;

   logic [15:0] mem_q [0:(1<<ADDR_WORDS)-1];

   logic req;
   logic legal;
   logic commit;

   assign req = bus.Rd | bus.Wr;

`ifdef DMEM_ALIGN_CHK_EN
   assign legal = (bus.Rd ^ bus.Wr) & ~bus.Addr[0];
`else
   assign legal = bus.Rd ^ bus.Wr;
`endif

   // Upper address bits alias; Addr[0] only matters with the alignment check.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.Addr[15:ADDR_WORDS+1], bus.Addr[0]};

   // The access happens on the edge that leaves WAIT.
   assign commit = (state_q == WAIT) && (count_q == 4'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= 4'd0;
         addr_q  <= '0;
         wdata_q <= 16'h0000;
         wr_q    <= 1'b0;
         dout_q  <= 16'h0000;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req && legal) begin
                  state_q <= WAIT;
                  addr_q  <= bus.Addr[ADDR_WORDS:1];
                  wdata_q <= bus.DataIn;
                  wr_q    <= bus.Wr;
                  count_q <= COUNT_LOAD;
               end else if (req) begin
                  err_q <= 1'b1;
               end
            end
            WAIT: begin
               if (count_q != 4'd0) begin
                  count_q <= count_q - 4'd1;
               end else begin
                  state_q <= RESP;
                  done_q  <= 1'b1;
                  if (!wr_q) begin
                     dout_q <= mem_q[addr_q];
                  end
               end
            end
            RESP: begin
               // Core still holds Rd/Wr here; they are deliberately ignored.
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Storage array is not reset; an async reset forces IDLE so an aborted
   // write can never reach the commit edge.
   always_ff @(posedge clk) begin
      if (commit && wr_q) begin
         mem_q[addr_q] <= wdata_q;
      end
   end

   assign bus.Stall   = ((state_q == IDLE) && req && legal) || (state_q == WAIT);
   assign bus.DataOut = dout_q;
   assign bus.Done    = done_q;
   assign bus.Err     = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

   localparam int LAT = 4;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   dmem_responder_if bus ();

   dmem_responder #(.LATENCY(LAT), .ADDR_WORDS(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one request, holds it until Done (bounded), then releases it and
   // lets the FSM return to IDLE. edges = posedges from drive to Done seen.
   task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] data, output int edges,
                         output logic [15:0] dout, output logic seen);
      bus.Rd = rd;
      bus.Wr = wr;
      bus.Addr = addr;
      bus.DataIn = data;
      edges = 0;
      seen = 1'b0;
      dout = 16'h0000;
      while (!seen && edges < 30) begin
         @(posedge clk);
         #1;
         edges++;
         if (bus.Done === 1'b1) begin
            seen = 1'b1;
            dout = bus.DataOut;
         end
      end
      bus.Rd = 1'b0;
      bus.Wr = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int e;
      logic [15:0] d;
      logic s;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if (bus.DataOut !== 16'h0000 || bus.Stall !== 1'b0 || bus.Done !== 1'b0 || bus.Err !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: DataOut=%h Stall=%b Done=%b Err=%b, required 0000 0 0 0",
                  bus.DataOut, bus.Stall, bus.Done, bus.Err);
      end
      @(posedge clk);
      #1;
      access(1'b0, 1'b1, 16'h0010, 16'h1111, e, d, s);
      // Abort a second write to the same word in the middle of WAIT.
      bus.Wr = 1'b1;
      bus.Addr = 16'h0010;
      bus.DataIn = 16'h2222;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      bus.Wr = 1'b0;
      #2;
      checks++;
      if (bus.Stall !== 1'b0 || bus.DataOut !== 16'h0000) begin
         errors++;
         $display("FAIL reset_midwait: Stall=%b DataOut=%h, required 0 0000", bus.Stall, bus.DataOut);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      access(1'b1, 1'b0, 16'h0010, 16'h0000, e, d, s);
      checks++;
      if (s !== 1'b1 || d !== 16'h1111) begin
         errors++;
         $display("FAIL reset_no_commit: done=%b data=%h, required 1 1111", s, d);
      end
   endtask

   task automatic test_latency();
      int e;
      logic [15:0] d;
      logic s;
      int stall_bad;
      bus.Wr = 1'b1;
      bus.Addr = 16'h0020;
      bus.DataIn = 16'hBEEF;
      #1;
      checks++;
      if (bus.Stall !== 1'b1) begin
         errors++;
         $display("FAIL stall_on_request: Stall=%b, required 1", bus.Stall);
      end
      @(posedge clk);
      #1;
      stall_bad = 0;
      for (int i = 0; i < LAT; i++) begin
         if (bus.Stall !== 1'b1 || bus.Done !== 1'b0) stall_bad++;
         @(posedge clk);
         #1;
      end
      checks++;
      if (stall_bad != 0) begin
         errors++;
         $display("FAIL stall_wait: %0d bad cycles of %0d, required 0", stall_bad, LAT);
      end
      checks++;
      if (bus.Done !== 1'b1 || bus.Stall !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse: Done=%b Stall=%b, required 1 0", bus.Done, bus.Stall);
      end
      bus.Wr = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (bus.Done !== 1'b0 || bus.Stall !== 1'b0) begin
         errors++;
         $display("FAIL done_one_cycle: Done=%b Stall=%b, required 0 0", bus.Done, bus.Stall);
      end
      access(1'b1, 1'b0, 16'h0020, 16'h0000, e, d, s);
      checks++;
      if (s !== 1'b1 || e != LAT + 1 || d !== 16'hBEEF) begin
         errors++;
         $display("FAIL read_latency: done=%b edges=%0d data=%h, required 1 %0d beef", s, e, d, LAT + 1);
      end
   endtask

   task automatic test_input_hold();
      int e;
      logic [15:0] d;
      logic s;
      bus.Wr = 1'b1;
      bus.Addr = 16'h0040;
      bus.DataIn = 16'h1234;
      @(posedge clk);
      #1;
      bus.Addr = 16'hFFFF;
      bus.DataIn = 16'hFFFF;
      s = 1'b0;
      for (int i = 0; i < 30 && !s; i++) begin
         @(posedge clk);
         #1;
         if (bus.Done === 1'b1) s = 1'b1;
      end
      bus.Wr = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (s !== 1'b1) begin
         errors++;
         $display("FAIL hold_done: done=%b, required 1", s);
      end
      access(1'b1, 1'b0, 16'h0040, 16'h0000, e, d, s);
      checks++;
      if (d !== 16'h1234) begin
         errors++;
         $display("FAIL hold_inputs: data=%h, required 1234", d);
      end
   endtask

   task automatic test_illegal();
      int e;
      logic [15:0] d;
      logic s;
      access(1'b0, 1'b1, 16'h0002, 16'h5555, e, d, s);
      bus.Rd = 1'b1;
      bus.Wr = 1'b1;
      bus.Addr = 16'h0002;
      bus.DataIn = 16'h9999;
      #1;
      checks++;
      if (bus.Stall !== 1'b0) begin
         errors++;
         $display("FAIL illegal_stall: Stall=%b, required 0", bus.Stall);
      end
      @(posedge clk);
      #1;
      bus.Rd = 1'b0;
      bus.Wr = 1'b0;
      checks++;
      if (bus.Err !== 1'b1 || bus.Done !== 1'b0 || bus.Stall !== 1'b0) begin
         errors++;
         $display("FAIL illegal_err: Err=%b Done=%b Stall=%b, required 1 0 0", bus.Err, bus.Done, bus.Stall);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.Err !== 1'b0) begin
         errors++;
         $display("FAIL illegal_err_pulse: Err=%b, required 0", bus.Err);
      end
      // Still IDLE: a following read is accepted on the first edge.
      access(1'b1, 1'b0, 16'h0002, 16'h0000, e, d, s);
      checks++;
      if (d !== 16'h5555 || e != LAT + 1) begin
         errors++;
         $display("FAIL illegal_no_change: data=%h edges=%0d, required 5555 %0d", d, e, LAT + 1);
      end
   endtask

   task automatic test_alias();
      int e;
      logic [15:0] d;
      logic s;
      access(1'b0, 1'b1, 16'h0802, 16'hA5A5, e, d, s);
      access(1'b1, 1'b0, 16'h0002, 16'h0000, e, d, s);
      checks++;
      if (d !== 16'hA5A5) begin
         errors++;
         $display("FAIL alias: data=%h, required a5a5", d);
      end
   endtask

   task automatic test_odd_addr();
      int e;
      logic [15:0] d;
      logic s;
`ifdef DMEM_ALIGN_CHK_EN
      bus.Wr = 1'b1;
      bus.Addr = 16'h0003;
      bus.DataIn = 16'h7777;
      #1;
      checks++;
      if (bus.Stall !== 1'b0) begin
         errors++;
         $display("FAIL odd_stall: Stall=%b, required 0", bus.Stall);
      end
      @(posedge clk);
      #1;
      bus.Wr = 1'b0;
      checks++;
      if (bus.Err !== 1'b1 || bus.Done !== 1'b0) begin
         errors++;
         $display("FAIL odd_err: Err=%b Done=%b, required 1 0", bus.Err, bus.Done);
      end
      @(posedge clk);
      #1;
      access(1'b1, 1'b0, 16'h0002, 16'h0000, e, d, s);
      checks++;
      if (d !== 16'hA5A5) begin
         errors++;
         $display("FAIL odd_no_write: data=%h, required a5a5", d);
      end
`else
      access(1'b0, 1'b1, 16'h0003, 16'h7777, e, d, s);
      checks++;
      if (s !== 1'b1 || e != LAT + 1) begin
         errors++;
         $display("FAIL odd_done: done=%b edges=%0d, required 1 %0d", s, e, LAT + 1);
      end
      access(1'b1, 1'b0, 16'h0002, 16'h0000, e, d, s);
      checks++;
      if (d !== 16'h7777) begin
         errors++;
         $display("FAIL odd_word: data=%h, required 7777", d);
      end
`endif
   endtask

   task automatic test_back_to_back();
      int e;
      logic [15:0] d;
      logic s;
      access(1'b0, 1'b1, 16'h0100, 16'hC0DE, e, d, s);
      access(1'b0, 1'b1, 16'h0102, 16'hF00D, e, d, s);
      checks++;
      if (s !== 1'b1 || e != LAT + 1) begin
         errors++;
         $display("FAIL b2b_write: done=%b edges=%0d, required 1 %0d", s, e, LAT + 1);
      end
      access(1'b1, 1'b0, 16'h0100, 16'h0000, e, d, s);
      checks++;
      if (d !== 16'hC0DE) begin
         errors++;
         $display("FAIL b2b_read0: data=%h, required c0de", d);
      end
      access(1'b1, 1'b0, 16'h0102, 16'h0000, e, d, s);
      checks++;
      if (d !== 16'hF00D) begin
         errors++;
         $display("FAIL b2b_read1: data=%h, required f00d", d);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      bus.Rd = 1'b0;
      bus.Wr = 1'b0;
      bus.Addr = 16'h0000;
      bus.DataIn = 16'h0000;
      test_reset();
      test_latency();
      test_input_hold();
      test_illegal();
      test_alias();
      test_odd_addr();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
